// File: rtl/if_id_skid_if.sv
// IF/ID handshake bundle: fetch-side push channel, decode-side pop channel,
// flush request and occupancy readback.
interface if_id_skid_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [DATA_W-1:0] in_instr;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_instr;
    logic [1:0]        occupancy;

    // Environment side: drives fetches, flush and the ID stall.
    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, occupancy
    );

    // Pipeline register side.
    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, occupancy
    );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline register built as a 2-entry skid buffer. The head register
// (main) drives ID directly; the skid register absorbs the one extra fetch
// that arrives while ID stalls, so the stall never reaches IF combinationally.
// A flush empties both entries and drops any fetch accepted in that cycle.
module if_id_skid #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic           clock,
    input  logic           reset,
    if_id_skid_if.slave    bus
);
    // Encoding equals the number of entries held, so occupancy is the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] main_pc_r;
    logic [ADDR_W-1:0] main_pc_s;
    logic [DATA_W-1:0] main_instr_r;
    logic [DATA_W-1:0] main_instr_s;
    logic [ADDR_W-1:0] skid_pc_r;
    logic [ADDR_W-1:0] skid_pc_s;
    logic [DATA_W-1:0] skid_instr_r;
    logic [DATA_W-1:0] skid_instr_s;
    logic              in_fire_s;
    logic              out_fire_s;

    // Handshake outputs come straight from registers; main is kept zero while
    // empty so ID sees a NOP bubble without any output muxing.
    assign bus.in_ready  = (state_r != TWO);
    assign bus.out_valid = (state_r != EMPTY);
    assign bus.out_pc    = main_pc_r;
    assign bus.out_instr = main_instr_r;
    assign bus.occupancy = state_r;

    assign in_fire_s  = bus.in_valid & (state_r != TWO);
    assign out_fire_s = bus.out_ready & (state_r != EMPTY);

    // Next-state and storage update; flush overrides every other transition.
    always_comb begin
        state_s      = state_r;
        main_pc_s    = main_pc_r;
        main_instr_s = main_instr_r;
        skid_pc_s    = skid_pc_r;
        skid_instr_s = skid_instr_r;
        if (bus.flush) begin
            state_s      = EMPTY;
            main_pc_s    = {ADDR_W{1'b0}};
            main_instr_s = {DATA_W{1'b0}};
            skid_pc_s    = {ADDR_W{1'b0}};
            skid_instr_s = {DATA_W{1'b0}};
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_s      = ONE;
                        main_pc_s    = bus.in_pc;
                        main_instr_s = bus.in_instr;
                    end else begin
                        state_s = EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && !out_fire_s) begin
                        state_s      = TWO;
                        skid_pc_s    = bus.in_pc;
                        skid_instr_s = bus.in_instr;
                    end else if (out_fire_s && !in_fire_s) begin
                        state_s      = EMPTY;
                        main_pc_s    = {ADDR_W{1'b0}};
                        main_instr_s = {DATA_W{1'b0}};
                    end else if (in_fire_s && out_fire_s) begin
                        state_s      = ONE;
                        main_pc_s    = bus.in_pc;
                        main_instr_s = bus.in_instr;
                    end else begin
                        state_s = ONE;
                    end
                end
                TWO: begin
                    if (out_fire_s) begin
                        state_s      = ONE;
                        main_pc_s    = skid_pc_r;
                        main_instr_s = skid_instr_r;
                        skid_pc_s    = {ADDR_W{1'b0}};
                        skid_instr_s = {DATA_W{1'b0}};
                    end else begin
                        state_s = TWO;
                    end
                end
                default: begin
                    state_s      = EMPTY;
                    main_pc_s    = {ADDR_W{1'b0}};
                    main_instr_s = {DATA_W{1'b0}};
                    skid_pc_s    = {ADDR_W{1'b0}};
                    skid_instr_s = {DATA_W{1'b0}};
                end
            endcase
        end
    end

    // State and entry registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= EMPTY;
            main_pc_r    <= {ADDR_W{1'b0}};
            main_instr_r <= {DATA_W{1'b0}};
            skid_pc_r    <= {ADDR_W{1'b0}};
            skid_instr_r <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_s;
            main_pc_r    <= main_pc_s;
            main_instr_r <= main_instr_s;
            skid_pc_r    <= skid_pc_s;
            skid_instr_r <= skid_instr_s;
        end
    end
endmodule

// File: tb/tb_if_id_skid.sv
// Bench for the IF/ID skid buffer: directed scenarios followed by random
// traffic, all checked against a queue-based FIFO reference model.
module tb_if_id_skid;
    logic clock;
    logic reset;
    int   n_assert;
    int   n_fail;
    logic [63:0] model_q[$];

    if_id_skid_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    if_id_skid #(.DATA_W(32), .ADDR_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's view of the FIFO.
    task automatic check_all(input string tag);
        logic [31:0] epc;
        logic [31:0] ein;
        epc = (model_q.size() != 0) ? model_q[0][63:32] : 32'h0;
        ein = (model_q.size() != 0) ? model_q[0][31:0]  : 32'h0;
        chk({tag, "_valid"}, {63'd0, bus.out_valid}, {63'd0, model_q.size() != 0});
        chk({tag, "_ready"}, {63'd0, bus.in_ready},  {63'd0, model_q.size() < 2});
        chk({tag, "_occ"},   {62'd0, bus.occupancy}, 64'(model_q.size()));
        chk({tag, "_pc"},    {32'd0, bus.out_pc},    {32'd0, epc});
        chk({tag, "_instr"}, {32'd0, bus.out_instr}, {32'd0, ein});
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = instr;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    // One clock: decide fires from the model, advance it at the edge, check at negedge.
    task automatic step(input string tag);
        bit in_fire;
        bit out_fire;
        in_fire  = bus.in_valid && (model_q.size() < 2);
        out_fire = bus.out_ready && (model_q.size() != 0);
        @(posedge clock);
        if (bus.flush) begin
            model_q.delete();
        end else begin
            if (out_fire) void'(model_q.pop_front());
            if (in_fire) model_q.push_back({bus.in_pc, bus.in_instr});
        end
        @(negedge clock);
        check_all(tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        check_all("rst");
        reset = 1'b1;
        step("rst_rel");

        // Stream three instructions with ID always ready.
        drive(1'b1, 32'd4, 32'h20080005, 1'b1, 1'b0);  step("s1");
        chk("s1_pc_lit", {32'd0, bus.out_pc}, 64'd4);
        drive(1'b1, 32'd8, 32'h20090003, 1'b1, 1'b0);  step("s2");
        chk("s2_instr_lit", {32'd0, bus.out_instr}, 64'h20090003);
        drive(1'b1, 32'd12, 32'h01095020, 1'b1, 1'b0); step("s3");
        chk("s3_occ_lit", {62'd0, bus.occupancy}, 64'd1);
        drive(1'b0, 32'd0, 32'h0, 1'b1, 1'b0);         step("s4");

        // ID stall: two pushes fill, third is ignored, then drain in order.
        drive(1'b1, 32'd4, 32'h11111111, 1'b0, 1'b0);  step("st1");
        drive(1'b1, 32'd8, 32'h22222222, 1'b0, 1'b0);  step("st2");
        chk("st2_ready_lit", {63'd0, bus.in_ready}, 64'd0);
        drive(1'b1, 32'd12, 32'h33333333, 1'b0, 1'b0); step("st3");
        chk("st3_pc_held", {32'd0, bus.out_pc}, 64'd4);
        drive(1'b0, 32'd0, 32'h0, 1'b1, 1'b0);         step("st4");
        chk("st4_pc_lit", {32'd0, bus.out_pc}, 64'd8);
        chk("st4_ready_lit", {63'd0, bus.in_ready}, 64'd1);
        step("st5");

        // Flush while full.
        drive(1'b1, 32'd4, 32'h44444444, 1'b0, 1'b0);  step("f1");
        drive(1'b1, 32'd8, 32'h55555555, 1'b0, 1'b0);  step("f2");
        drive(1'b0, 32'd0, 32'h0, 1'b0, 1'b1);         step("f3");
        chk("f3_occ_lit", {62'd0, bus.occupancy}, 64'd0);

        // Flush with a fetch in the same cycle from EMPTY: fetch dropped.
        drive(1'b1, 32'd16, 32'h66666666, 1'b0, 1'b1); step("f4");
        chk("f4_valid_lit", {63'd0, bus.out_valid}, 64'd0);
        drive(1'b0, 32'd0, 32'h0, 1'b0, 1'b0);         step("f5");

        // Simultaneous push and pop in ONE.
        drive(1'b1, 32'd4, 32'h77777777, 1'b0, 1'b0);  step("b1");
        drive(1'b1, 32'd8, 32'h88888888, 1'b1, 1'b0);  step("b2");
        chk("b2_pc_lit", {32'd0, bus.out_pc}, 64'd8);
        chk("b2_occ_lit", {62'd0, bus.occupancy}, 64'd1);
        drive(1'b0, 32'd0, 32'h0, 1'b1, 1'b0);         step("b3");

        // Asynchronous reset asserted mid-cycle with two entries held.
        drive(1'b1, 32'd4, 32'h99999999, 1'b0, 1'b0);  step("r1");
        drive(1'b1, 32'd8, 32'haaaaaaaa, 1'b0, 1'b0);  step("r2");
        #2 reset = 1'b0;
        #1;
        model_q.delete();
        chk("r_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("r_occ", {62'd0, bus.occupancy}, 64'd0);
        chk("r_instr", {32'd0, bus.out_instr}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 32'd0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("r_rel_ready", {63'd0, bus.in_ready}, 64'd1);
        step("r3");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                  $urandom, $urandom,
                  ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
